// File: rtl/run_scheduler.sv
// Fan session timer: IDLE/RUN/PAUSE/ALARM FSM with a mm:ss countdown and alarm buzzer.
// Optional feature macro: RUN_PAUSE_EN enables the pause input and the PAUSE state.
module run_scheduler #(
  parameter int MAX_MIN   = 99,
  parameter int ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       voice_1k,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [7:0] set_min,
  output logic       fan_en,
  output logic       beep,
  output logic [7:0] remmin,
  output logic [7:0] remsec,
  output logic [1:0] state,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_e;

  localparam logic [7:0]    MAXM  = 8'(MAX_MIN);
  localparam int            CW    = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [CW-1:0] ALAST = CW'(ALARM_SEC - 1);

  state_e        st_q, st_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [CW-1:0] acnt_q, acnt_d;
  logic          done_d;

  logic pause_cmd;
  logic start_ok;
  logic tick;
  logic last_sec;

`ifdef RUN_PAUSE_EN
  assign pause_cmd = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_cmd    = 1'b0;
`endif

  assign start_ok = start && (set_min != 8'd0) && (set_min <= MAXM);
  // Any command in the same cycle swallows the second tick.
  assign tick     = clk_1Hz && !(stop || start || pause_cmd);
  assign last_sec = (min_q == 8'd0) && (sec_q <= 8'd1);

  always_comb begin
    st_d   = st_q;
    min_d  = min_q;
    sec_d  = sec_q;
    acnt_d = acnt_q;
    done_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (start_ok) begin
          st_d  = RUN;
          min_d = set_min;
          sec_d = 8'd0;
        end
      end
      RUN: begin
        if (stop) begin
          st_d  = IDLE;
          min_d = 8'd0;
          sec_d = 8'd0;
        end else if (start) begin
          st_d = RUN;
        end else if (pause_cmd) begin
          st_d = PAUSE;
        end else if (tick) begin
          if (last_sec) begin
            st_d   = ALARM;
            min_d  = 8'd0;
            sec_d  = 8'd0;
            acnt_d = '0;
            done_d = 1'b1;
          end else if (sec_q != 8'd0) begin
            sec_d = sec_q - 8'd1;
          end else begin
            min_d = min_q - 8'd1;
            sec_d = 8'd59;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          st_d  = IDLE;
          min_d = 8'd0;
          sec_d = 8'd0;
        end else if (start || pause_cmd) begin
          st_d = RUN;
        end
      end
      ALARM: begin
        if (stop) begin
          st_d   = IDLE;
          min_d  = 8'd0;
          sec_d  = 8'd0;
          acnt_d = '0;
        end else if (start_ok) begin
          st_d   = RUN;
          min_d  = set_min;
          sec_d  = 8'd0;
          acnt_d = '0;
        end else if (tick) begin
          if (acnt_q == ALAST) begin
            st_d   = IDLE;
            acnt_d = '0;
          end else begin
            acnt_d = acnt_q + 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      min_q  <= 8'd0;
      sec_q  <= 8'd0;
      acnt_q <= '0;
      fan_en <= 1'b0;
      beep   <= 1'b0;
      done   <= 1'b0;
    end else begin
      st_q   <= st_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      acnt_q <= acnt_d;
      fan_en <= (st_d == RUN);
      beep   <= (st_d == ALARM) && voice_1k;
      done   <= done_d;
    end
  end

  assign state  = st_q;
  assign remmin = min_q;
  assign remsec = sec_q;

endmodule

// File: tb/tb_run_scheduler.sv
// Scoreboard bench for run_scheduler: seconds-based reference model, directed + random stimulus.
module tb_run_scheduler;
  localparam int MAX_MIN   = 99;
  localparam int ALARM_SEC = 5;
`ifdef RUN_PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       clk, rst_n, clk_1Hz, voice_1k, start, stop, pause;
  logic [7:0] set_min;
  logic       fan_en, beep, done;
  logic [7:0] remmin, remsec;
  logic [1:0] state;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       fan;
    logic       bp;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   dones    = 0;
  int   m_mode, m_rem, m_acnt;
  bit   vt = 1'b0;

  run_scheduler #(.MAX_MIN(MAX_MIN), .ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .rst_n(rst_n), .clk_1Hz(clk_1Hz), .voice_1k(voice_1k),
    .start(start), .stop(stop), .pause(pause), .set_min(set_min),
    .fan_en(fan_en), .beep(beep), .remmin(remmin), .remsec(remsec),
    .state(state), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs settled 1 time unit after each edge, compared to the queued expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {state, remmin, remsec, fan_en, beep, done};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t actual st=%0d %0d:%0d fan=%0b beep=%0b done=%0b required st=%0d %0d:%0d fan=%0b beep=%0b done=%0b",
                   $time, a.st, a.mn, a.sc, a.fan, a.bp, a.dn, e.st, e.mn, e.sc, e.fan, e.bp, e.dn);
        end
      end
    end
  end

  // Reference model: mode 0=idle 1=run 2=pause 3=alarm, time kept as total seconds.
  task automatic model(input bit st, input bit sp, input bit ps, input bit tk,
                       input logic [7:0] sm, input bit v);
    bit p, cmd, tick, ok, dn;
    int smi;
    exp_t e;
    smi  = int'(sm);
    p    = PE && ps;
    cmd  = sp || st || p;
    tick = tk && !cmd;
    ok   = st && (smi >= 1) && (smi <= MAX_MIN);
    dn   = 1'b0;
    case (m_mode)
      0: if (ok) begin m_rem = smi * 60; m_mode = 1; end
      1: begin
        if (sp) begin m_mode = 0; m_rem = 0; end
        else if (st) ;
        else if (p) m_mode = 2;
        else if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_mode = 3; m_acnt = 0; dn = 1'b1; end
        end
      end
      2: begin
        if (sp) begin m_mode = 0; m_rem = 0; end
        else if (st || p) m_mode = 1;
      end
      default: begin
        if (sp) begin m_mode = 0; m_rem = 0; m_acnt = 0; end
        else if (ok) begin m_rem = smi * 60; m_mode = 1; m_acnt = 0; end
        else if (tick) begin
          m_acnt++;
          if (m_acnt == ALARM_SEC) begin m_mode = 0; m_acnt = 0; end
        end
      end
    endcase
    e.st  = 2'(m_mode);
    e.mn  = 8'(m_rem / 60);
    e.sc  = 8'(m_rem % 60);
    e.fan = (m_mode == 1);
    e.bp  = (m_mode == 3) && v;
    e.dn  = dn;
    q.push_back(e);
  endtask

  task automatic drive(input bit st, input bit sp, input bit ps, input bit tk,
                       input logic [7:0] sm, input bit v);
    @(posedge clk);
    #2;
    rst_n = 1'b1; start = st; stop = sp; pause = ps; clk_1Hz = tk;
    set_min = sm; voice_1k = v;
    model(st, sp, ps, tk, sm, v);
  endtask

  task automatic go(input bit st, input bit sp, input bit ps, input bit tk, input logic [7:0] sm);
    drive(st, sp, ps, tk, sm, vt);
    vt = ~vt;
  endtask

  task automatic idle(input int n);
    repeat (n) go(0, 0, 0, 0, 8'd0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      go(0, 0, 0, 1, 8'd0);
      go(0, 0, 0, 0, 8'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 0; stop = 0; pause = 0; clk_1Hz = 0; set_min = 8'd0; voice_1k = 0;
    q.delete();
    #1;
    check("rst_state",  int'(state),  0);
    check("rst_remmin", int'(remmin), 0);
    check("rst_remsec", int'(remsec), 0);
    check("rst_fan",    int'(fan_en), 0);
    check("rst_beep",   int'(beep),   0);
    check("rst_done",   int'(done),   0);
    m_mode = 0; m_rem = 0; m_acnt = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int d0;
    logic [7:0] sm;
    rst_n = 1'b1; start = 0; stop = 0; pause = 0; clk_1Hz = 0;
    set_min = 8'd0; voice_1k = 0;
    do_reset();

    // invalid starts right after reset, then a valid one
    go(1, 0, 0, 0, 8'd0);
    go(1, 0, 0, 0, 8'd100);
    idle(1);
    check("invalid_idle", int'(state), 0);
    go(1, 0, 0, 0, 8'd1);
    idle(1);
    check("load_min", int'(remmin), 1);

    // full one-minute countdown, then alarm timeout
    d0 = dones;
    ticks(60);
    check("done_once", dones - d0, 1);
    check("alarm_state", int'(state), 3);
    ticks(5);
    check("alarm_exit", int'(state), 0);
    check("alarm_beep_off", int'(beep), 0);

    // pause at 00:30 for 10 ticks, resume, one tick, then stop
    go(1, 0, 0, 0, 8'd1);
    ticks(30);
    go(0, 0, 1, 0, 8'd0);
    ticks(10);
    go(0, 0, 1, 0, 8'd0);
    ticks(1);
    go(0, 1, 0, 0, 8'd0);
    idle(1);

    // stop+start together in RUN
    go(1, 0, 0, 0, 8'd3);
    ticks(2);
    go(1, 1, 0, 0, 8'd3);
    idle(1);
    check("stopstart_state", int'(state), 0);
    check("stopstart_min", int'(remmin), 0);

    // stop coincident with the final tick
    go(1, 0, 0, 0, 8'd1);
    ticks(59);
    check("at_0001", int'(remsec), 1);
    d0 = dones;
    go(0, 1, 0, 1, 8'd0);
    idle(2);
    check("no_done", dones - d0, 0);
    check("stop_final_state", int'(state), 0);

    // restart from ALARM with set_min=2
    go(1, 0, 0, 0, 8'd1);
    ticks(60);
    ticks(2);
    go(1, 0, 0, 0, 8'd2);
    idle(1);
    check("realarm_state", int'(state), 1);
    check("realarm_min", int'(remmin), 2);
    check("realarm_beep", int'(beep), 0);

    // asynchronous reset mid-session, then immediate restart
    ticks(3);
    do_reset();
    go(1, 0, 0, 0, 8'd2);
    ticks(3);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0: sm = 8'd0;
        1: sm = 8'd1;
        2: sm = 8'd2;
        3: sm = 8'd99;
        4: sm = 8'd100;
        5: sm = 8'd255;
        default: sm = 8'($urandom_range(1, 3));
      endcase
      if ($urandom_range(0, 999) == 0) do_reset();
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, sm,
            $urandom_range(0, 1) == 1);
    end

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_scheduler.md
RUN_SCHEDULER -- requirements
Module: run_scheduler

Interface
REQ-001 Parameter MAX_MIN, default 99: the largest accepted session length, in minutes.
REQ-002 Parameter ALARM_SEC, default 5: the alarm duration, in clk_1Hz ticks.
REQ-003 Port clk, input, 1: system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port clk_1Hz, input, 1: one-clk-wide tick pulse, once per second, synchronous to clk.
REQ-006 Port voice_1k, input, 1: 1 kHz tone, synchronous to clk.
REQ-007 Port start, input, 1: one-cycle pulse; starts or resumes a session.
REQ-008 Port stop, input, 1: one-cycle pulse; aborts the session.
REQ-009 Port pause, input, 1: one-cycle pulse; toggles pause.
REQ-010 Port set_min, input, 8: requested session length in minutes; sampled on start.
REQ-011 Port fan_en, output, 1: fan run enable.
REQ-012 Port beep, output, 1: buzzer drive.
REQ-013 Port remmin, output, 8: remaining minutes.
REQ-014 Port remsec, output, 8: remaining seconds, range 0..59.
REQ-015 Port state, output, 2: current FSM state.
REQ-016 Port done, output, 1: one-cycle pulse when a session completes.

Function
REQ-017 The FSM SHALL have four states encoded on state: IDLE=00, RUN=01, PAUSE=10, ALARM=11.
REQ-018 All outputs SHALL be registered; each state change SHALL be visible on the cycle after the triggering input.
REQ-019 When two commands arrive in the same cycle, priority SHALL be stop > start > pause; any clk_1Hz tick in that cycle is dropped.
REQ-020 IDLE: start with 1 <= set_min <= MAX_MIN SHALL load remmin=set_min, remsec=0 and enter RUN.
REQ-021 IDLE: start with set_min=0 or set_min>MAX_MIN SHALL be ignored; the FSM stays in IDLE.
REQ-022 RUN: fan_en=1; each tick SHALL decrement the remaining time:
- remsec>0: remsec-1;
- otherwise remmin-1 and remsec=59.
REQ-023 RUN: the tick that reaches 00:00 SHALL move the FSM to ALARM and assert done for exactly that one cycle.
REQ-024 RUN: stop SHALL move to IDLE and clear remmin/remsec; pause SHALL move to PAUSE.
REQ-025 PAUSE: fan_en=0; remmin/remsec SHALL be frozen and ticks ignored.
REQ-026 PAUSE: start or pause SHALL return to RUN; stop SHALL move to IDLE and clear the time.
REQ-027 ALARM: fan_en=0, and beep SHALL equal voice_1k delayed by one clk; in every other state beep=0.
REQ-028 ALARM: an internal tick counter SHALL move the FSM to IDLE on the ALARM_SEC-th tick.
REQ-029 ALARM: stop SHALL move to IDLE at once; a valid start SHALL reload the time and enter RUN.
REQ-030 stop arriving in the same cycle as the final tick SHALL move to IDLE with no done pulse.
REQ-031 remmin/remsec SHALL never wrap below 00:00.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE and fan_en=beep=done=0.
REQ-033 rst_n=0 SHALL also immediately clear remmin=remsec=0 and the alarm counter, including when asserted mid-session.
REQ-034 After rst_n rises, the first start SHALL be accepted on the next clk edge.

Configuration
REQ-035 With RUN_PAUSE_EN defined, the pause input and the PAUSE state SHALL behave as in REQ-024 to REQ-026.
REQ-036 Without RUN_PAUSE_EN, the pause input SHALL be ignored, state SHALL never equal 10, and a start in RUN SHALL be ignored.

Verification
REQ-037 Reset: assert rst_n=0 mid-RUN -> state=00, remmin=remsec=0, fan_en=0, beep=0, without waiting for a clk edge.
REQ-038 Countdown: set_min=1, start, then 60 ticks -> sequence 01:00, 00:59 ... 00:00; done=1 for one cycle on the 60th tick; state=11.
REQ-039 Alarm: ALARM_SEC=5 with voice_1k toggling -> beep follows voice_1k one clk late; after the 5th tick state=00 and beep=0.
REQ-040 Pause (RUN_PAUSE_EN): pause at 00:30, then 10 ticks -> time holds at 00:30 with fan_en=0; pause again -> RUN, and the next tick gives 00:29.
REQ-041 Invalid/priority: set_min=0 with start -> stays IDLE; set_min=100 with start -> stays IDLE; stop+start in the same cycle in RUN -> IDLE with the time cleared.
REQ-042 Boundary: stop coincident with the final tick at 00:01 -> state=00, done never asserted; start during ALARM with set_min=2 -> RUN at 02:00, beep=0.
